// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and default constants for the keypad supervisor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        KPS_LOCKED  = 2'd0,
        KPS_OPEN    = 2'd1,
        KPS_LOCKOUT = 2'd2,
        KPS_ALARM   = 2'd3
    } kps_state_e;

    localparam int KPS_MAX_FAIL_DEF    = 3;
    localparam int KPS_MAX_LOCKOUT_DEF = 2;
    localparam int KPS_LOCKOUT_CYC_DEF = 16;
    localparam int KPS_RELOCK_CYC_DEF  = 32;
    localparam int KPS_CW_DEF          = 6;

    // Status lines coming back from the keypad FSM
    typedef struct packed {
        logic rsto;
        logic ulck;
    } kp_status_t;

    typedef logic [2:0] kps_cnt_t;

endpackage

`default_nettype wire

// File: rtl/kps_timer.sv
// ============================================================================
// Module   : kps_timer
// Brief    : Loadable down-counter that saturates at zero; shared by the
//            lockout and auto-relock intervals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kps_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/keypad_supervisor.sv
// ============================================================================
// Module   : keypad_supervisor
// Brief    : Supervises the keypad combination FSM: failure counting, timed
//            lockout, alarm escalation and open/relock handling.
//            Define KPS_AUTO_RELOCK_EN to relock OPEN after RELOCK_CYC clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_supervisor
    import keypad_pkg::*;
#(
    parameter int MAX_FAIL    = KPS_MAX_FAIL_DEF,
    parameter int MAX_LOCKOUT = KPS_MAX_LOCKOUT_DEF,
    parameter int LOCKOUT_CYC = KPS_LOCKOUT_CYC_DEF,
    parameter int RELOCK_CYC  = KPS_RELOCK_CYC_DEF,
    parameter int CW          = KPS_CW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kp_rsto,
    input  logic       kp_ulck,
    input  logic       door_close,
    input  logic       admin_clr,
    output logic       kp_enbl,
    output logic       kp_clr,
    output logic       open,
    output logic       lockout,
    output logic       alarm,
    output logic [2:0] fail_cnt,
    output logic [2:0] lock_cnt,
    output logic [1:0] state
);

    localparam kps_cnt_t      MAX_FAIL_C    = 3'(MAX_FAIL);
    localparam kps_cnt_t      MAX_LOCKOUT_C = 3'(MAX_LOCKOUT);
    localparam logic [CW-1:0] LOCKOUT_LOAD  = CW'(LOCKOUT_CYC - 1);
    localparam logic [CW-1:0] RELOCK_LOAD   = CW'(RELOCK_CYC - 1);

    kps_state_e cur_state;
    kp_status_t kp_now;
    kp_status_t kp_q;

    logic          armed;
    logic          fail_ev;
    logic          ulck_ev;
    logic          unlock_go;
    kps_cnt_t      fail_next;
    kps_cnt_t      lock_next;
    logic          fail_trip;
    logic          alarm_trip;
    logic          timer_load;
    logic          timer_en;
    logic          timer_zero;
    logic          relock_due;
    logic [CW-1:0] timer_val;

    assign kp_now = '{rsto: kp_rsto, ulck: kp_ulck};

    // Edges only count while the keypad is actually enabled in LOCKED
    assign armed     = (cur_state == KPS_LOCKED) && kp_enbl;
    assign fail_ev   = armed && kp_now.rsto && !kp_q.rsto;
    assign ulck_ev   = armed && kp_now.ulck && !kp_q.ulck;
    assign unlock_go = ulck_ev && !fail_ev;

    assign fail_next  = fail_cnt + 3'd1;
    assign lock_next  = lock_cnt + 3'd1;
    assign fail_trip  = fail_ev && (fail_next == MAX_FAIL_C);
    assign alarm_trip = fail_trip && (lock_next == MAX_LOCKOUT_C);

    assign timer_load = (fail_trip && !alarm_trip) || unlock_go;
    assign timer_val  = unlock_go ? RELOCK_LOAD : LOCKOUT_LOAD;

`ifdef KPS_AUTO_RELOCK_EN
    assign timer_en   = (cur_state == KPS_LOCKOUT) || (cur_state == KPS_OPEN);
    assign relock_due = (cur_state == KPS_OPEN) && timer_zero;
`else
    assign timer_en   = (cur_state == KPS_LOCKOUT);
    assign relock_due = 1'b0;
`endif

    kps_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= KPS_LOCKED;
            kp_clr    <= 1'b1;
            fail_cnt  <= 3'd0;
            lock_cnt  <= 3'd0;
            kp_q      <= '0;
        end else begin
            kp_q   <= kp_now;
            kp_clr <= 1'b0;
            case (cur_state)
                KPS_LOCKED: begin
                    if (fail_ev) begin
                        if (fail_trip) begin
                            fail_cnt <= 3'd0;
                            // lock_cnt stays below MAX_LOCKOUT when escalating
                            if (alarm_trip) begin
                                cur_state <= KPS_ALARM;
                            end else begin
                                cur_state <= KPS_LOCKOUT;
                                lock_cnt  <= lock_next;
                            end
                        end else begin
                            fail_cnt <= fail_next;
                        end
                    end else if (ulck_ev) begin
                        cur_state <= KPS_OPEN;
                        fail_cnt  <= 3'd0;
                        lock_cnt  <= 3'd0;
                    end
                end
                KPS_OPEN: begin
                    if (door_close || relock_due) begin
                        cur_state <= KPS_LOCKED;
                        kp_clr    <= 1'b1;
                    end
                end
                KPS_LOCKOUT: begin
                    if (timer_zero) begin
                        cur_state <= KPS_LOCKED;
                        kp_clr    <= 1'b1;
                    end
                end
                KPS_ALARM: begin
                    if (admin_clr) begin
                        cur_state <= KPS_LOCKED;
                        kp_clr    <= 1'b1;
                        fail_cnt  <= 3'd0;
                        lock_cnt  <= 3'd0;
                    end
                end
                default: begin
                    cur_state <= KPS_LOCKED;
                    kp_clr    <= 1'b1;
                end
            endcase
        end
    end

    assign kp_enbl = (cur_state == KPS_LOCKED) && !kp_clr;
    assign open    = (cur_state == KPS_OPEN);
    assign lockout = (cur_state == KPS_LOCKOUT);
    assign alarm   = (cur_state == KPS_ALARM);
    assign state   = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_keypad_supervisor.sv
// ============================================================================
// Module   : tb_keypad_supervisor
// Brief    : Directed self-checking bench for keypad_supervisor (default
//            parameters; KPS_AUTO_RELOCK_EN selects the relock expectation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_supervisor;

    logic       clk = 1'b0;
    logic       reset;
    logic       kp_rsto;
    logic       kp_ulck;
    logic       door_close;
    logic       admin_clr;
    logic       kp_enbl;
    logic       kp_clr;
    logic       open;
    logic       lockout;
    logic       alarm;
    logic [2:0] fail_cnt;
    logic [2:0] lock_cnt;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    keypad_supervisor dut (
        .clk        (clk),
        .reset      (reset),
        .kp_rsto    (kp_rsto),
        .kp_ulck    (kp_ulck),
        .door_close (door_close),
        .admin_clr  (admin_clr),
        .kp_enbl    (kp_enbl),
        .kp_clr     (kp_clr),
        .open       (open),
        .lockout    (lockout),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt),
        .lock_cnt   (lock_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; outputs are then read 1 time unit after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fail_pulse();
        kp_rsto = 1'b1;
        step(1);
        kp_rsto = 1'b0;
        step(1);
    endtask

    initial begin
        int n;
        reset = 1'b1; kp_rsto = 1'b0; kp_ulck = 1'b0;
        door_close = 1'b0; admin_clr = 1'b0;
        step(2);
        check("rst_kp_clr", kp_clr, 1);
        check("rst_kp_enbl", kp_enbl, 0);
        check("rst_state", state, 0);
        check("rst_flags", {open, lockout, alarm}, 0);
        check("rst_counts", {fail_cnt, lock_cnt}, 0);
        reset = 1'b0;
        step(1);
        check("post_rst_kp_clr", kp_clr, 0);
        check("post_rst_kp_enbl", kp_enbl, 1);

        // Unlock then door close
        kp_ulck = 1'b1;
        step(1);
        check("unlock_open", open, 1);
        check("unlock_state", state, 1);
        check("unlock_kp_enbl", kp_enbl, 0);
        kp_ulck = 1'b0;
        step(4);
        door_close = 1'b1;
        step(1);
        check("relock_open", open, 0);
        check("relock_kp_clr", kp_clr, 1);
        check("relock_kp_enbl", kp_enbl, 0);
        door_close = 1'b0;
        step(1);
        check("relock_clr_once", kp_clr, 0);
        check("relock_enbl", kp_enbl, 1);
        check("relock_counts", {fail_cnt, lock_cnt}, 0);

        // Three failures -> 16-cycle lockout, unlock ignored inside it
        kp_rsto = 1'b1; step(1);
        check("fail1_cnt", fail_cnt, 1);
        kp_rsto = 1'b0; step(1);
        kp_rsto = 1'b1; step(1);
        check("fail2_cnt", fail_cnt, 2);
        kp_rsto = 1'b0; step(1);
        kp_rsto = 1'b1; step(1);
        check("fail3_lockout", lockout, 1);
        check("fail3_fail_cnt", fail_cnt, 0);
        check("fail3_lock_cnt", lock_cnt, 1);
        kp_rsto = 1'b0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) kp_ulck = 1'b1;
            if (i == 4) kp_ulck = 1'b0;
            step(1);
            if (lockout) n++;
            else break;
        end
        check("lockout_len", n, 16);
        check("lockout_exit_kp_clr", kp_clr, 1);
        check("lockout_ulck_ignored", open, 0);
        check("lockout_exit_state", state, 0);
        step(1);
        check("lockout_exit_enbl", kp_enbl, 1);
        check("lockout_exit_lock_cnt", lock_cnt, 1);

        // Second lockout escalates to alarm
        fail_pulse();
        fail_pulse();
        kp_rsto = 1'b1; step(1);
        check("alarm_on", alarm, 1);
        check("alarm_state", state, 3);
        check("alarm_kp_enbl", kp_enbl, 0);
        check("alarm_fail_cnt", fail_cnt, 0);
        kp_rsto = 1'b0;
        door_close = 1'b1; step(1);
        check("alarm_door_ignored", alarm, 1);
        door_close = 1'b0; step(3);
        check("alarm_held", alarm, 1);
        admin_clr = 1'b1; step(1);
        check("admin_state", state, 0);
        check("admin_kp_clr", kp_clr, 1);
        check("admin_counts", {fail_cnt, lock_cnt}, 0);
        admin_clr = 1'b0; step(1);
        check("admin_enbl", kp_enbl, 1);

        // Simultaneous fail and unlock edges: fail wins
        kp_rsto = 1'b1; kp_ulck = 1'b1; step(1);
        check("simul_fail_cnt", fail_cnt, 1);
        check("simul_open", open, 0);
        kp_rsto = 1'b0; kp_ulck = 1'b0; step(1);

        // Open and wait
        kp_ulck = 1'b1; step(1);
        check("wait_open", open, 1);
        check("wait_fail_clr", fail_cnt, 0);
        kp_ulck = 1'b0;
`ifdef KPS_AUTO_RELOCK_EN
        n = 1;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (open) n++;
            else break;
        end
        check("auto_relock_len", n, 32);
        check("auto_relock_kp_clr", kp_clr, 1);
        step(1);
`else
        step(100);
        check("hold_open", open, 1);
        door_close = 1'b1; step(1);
        door_close = 1'b0;
        check("hold_relock_kp_clr", kp_clr, 1);
        step(1);
`endif
        check("wait_enbl", kp_enbl, 1);

        // Reset in the middle of a lockout
        fail_pulse();
        fail_pulse();
        kp_rsto = 1'b1; step(1);
        kp_rsto = 1'b0;
        check("mid_lockout", lockout, 1);
        step(3);
        reset = 1'b1; step(1);
        check("midrst_state", state, 0);
        check("midrst_kp_clr", kp_clr, 1);
        check("midrst_kp_enbl", kp_enbl, 0);
        check("midrst_flags", {open, lockout, alarm}, 0);
        check("midrst_counts", {fail_cnt, lock_cnt}, 0);
        reset = 1'b0; step(1);
        check("midrst_enbl", kp_enbl, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
